branch_target_predictor: RTL and testbench

- Parametrised branch target buffer with 2-bit saturating-counter direction prediction. Successor of the fixed branch prediction table in the 5-stage RISC-V pipeline.
- Placement:
  - IF stage: looks up the current PC and returns a predicted direction and next PC in the same cycle.
  - ID stage: trains the table with the resolved branch outcome.
- Configurable table depth and address width; optional synchronous invalidate and optional statistics counters.

---
 rtl/branch_target_predictor.sv | 167 ++++++++++++++++
 tb/tb_branch_target_predictor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped branch target buffer with 2-bit
// saturating direction counters; same-cycle lookup, next-cycle training.
//
// Parameters:
//   DATA_W   PC / target width
//   ENTRIES  table depth, power of two in 2..256
//   INDEX_W  derived index width, TAG_W derived tag width (do not override)
//
// Ports:
//   clk, arst           clock, asynchronous active-high reset
//   lookup_en           IF stage valid (feeds the lookup statistic only)
//   lookup_pc           IF stage PC
//   predict_taken/_pc   combinational prediction for lookup_pc
//   update_*            resolved branch from ID (valid/pc/target/taken/mispredict)
//   flush_all           synchronous invalidate of every entry
//   stat_lookups        lookup counter, present with BTP_STATS_EN
//   stat_mispredicts    mispredict counter, present with BTP_STATS_EN
//
// Optional feature macro: BTP_STATS_EN (statistics counters). When it is not
// defined both stat outputs are tied to zero and no counters exist.

module branch_target_predictor #(
    parameter int DATA_W  = 64,
    parameter int ENTRIES = 16,
    parameter int INDEX_W = $clog2(ENTRIES),
    parameter int TAG_W   = DATA_W - INDEX_W - 2
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              lookup_en,
    input  logic [DATA_W-1:0] lookup_pc,
    output logic              predict_taken,
    output logic [DATA_W-1:0] predict_pc,
    input  logic              update_valid,
    input  logic [DATA_W-1:0] update_pc,
    input  logic [DATA_W-1:0] update_target,
    input  logic              update_taken,
    input  logic              update_mispredict,
    input  logic              flush_all,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_mispredicts
);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [DATA_W-1:0] target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;

    logic [INDEX_W-1:0] up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;

    // Next state of the single entry addressed by update_pc.
    logic               wr_en;
    logic               valid_d;
    logic [TAG_W-1:0]   tag_d;
    logic [DATA_W-1:0]  target_d;
    logic [1:0]         ctr_d;

    assign lk_idx = lookup_pc[INDEX_W+1:2];
    assign lk_tag = lookup_pc[DATA_W-1:INDEX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    // Lookup reads only the registers, so a same-cycle update is not seen.
    assign predict_taken = lk_hit && ctr_q[lk_idx][1];
    assign predict_pc    = predict_taken ? target_q[lk_idx]
                                         : lookup_pc + DATA_W'(4);

    assign up_idx = update_pc[INDEX_W+1:2];
    assign up_tag = update_pc[DATA_W-1:INDEX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        wr_en    = 1'b0;
        valid_d  = valid_q[up_idx];
        tag_d    = tag_q[up_idx];
        target_d = target_q[up_idx];
        ctr_d    = ctr_q[up_idx];
        if (update_valid) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (update_taken) begin
                    target_d = update_target;
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d = ctr_q[up_idx] + 2'd1;
                    end
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d = ctr_q[up_idx] - 2'd1;
                end
            end else if (update_taken) begin
                // Taken miss allocates (or replaces) in weakly-taken state.
                wr_en    = 1'b1;
                valid_d  = 1'b1;
                tag_d    = up_tag;
                target_d = update_target;
                ctr_d    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (flush_all) begin
            // Flush wins over a same-cycle update; targets/counters survive.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            valid_q[up_idx]  <= valid_d;
            tag_q[up_idx]    <= tag_d;
            target_q[up_idx] <= target_d;
            ctr_q[up_idx]    <= ctr_d;
        end
    end

`ifdef BTP_STATS_EN
    logic [31:0] lookups_q;
    logic [31:0] lookups_d;
    logic [31:0] mispred_q;
    logic [31:0] mispred_d;

    always_comb begin
        lookups_d = lookups_q;
        mispred_d = mispred_q;
        if (lookup_en && (lookups_q != 32'hFFFF_FFFF)) begin
            lookups_d = lookups_q + 32'd1;
        end
        if (update_valid && update_mispredict &&
            (mispred_q != 32'hFFFF_FFFF)) begin
            mispred_d = mispred_q + 32'd1;
        end
    end

    // Cleared by reset only; flush_all leaves the statistics intact.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            lookups_q <= lookups_d;
            mispred_q <= mispred_d;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispred_q;
`else
    assign stat_lookups     = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

    // Byte-offset bits never address the table; the enables only feed stats.
    logic unused_inputs;
    assign unused_inputs = ^{lookup_pc[1:0], update_pc[1:0],
                             lookup_en, update_mispredict};

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed steps then
// randomized traffic compared against an array-based reference model.

module tb_branch_target_predictor;

    localparam int DW = 64;
    localparam int NE = 16;
    localparam int IW = 4;

    logic          clk;
    logic          arst;
    logic          lookup_en;
    logic [DW-1:0] lookup_pc;
    logic          predict_taken;
    logic [DW-1:0] predict_pc;
    logic          update_valid;
    logic [DW-1:0] update_pc;
    logic [DW-1:0] update_target;
    logic          update_taken;
    logic          update_mispredict;
    logic          flush_all;
    logic [31:0]   stat_lookups;
    logic [31:0]   stat_mispredicts;

    branch_target_predictor #(.DATA_W(DW), .ENTRIES(NE)) dut (
        .clk               (clk),
        .arst              (arst),
        .lookup_en         (lookup_en),
        .lookup_pc         (lookup_pc),
        .predict_taken     (predict_taken),
        .predict_pc        (predict_pc),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_target     (update_target),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .flush_all         (flush_all),
        .stat_lookups      (stat_lookups),
        .stat_mispredicts  (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: plain arrays keyed by (pc/4) mod NE.
    bit            m_valid  [NE];
    logic [DW-1:0] m_tag    [NE];
    logic [DW-1:0] m_target [NE];
    int            m_ctr    [NE];
    longint        m_lookups;
    longint        m_mispred;

    function automatic int idx_of(input logic [DW-1:0] pc);
        return int'((pc / 4) % NE);
    endfunction

    function automatic logic [DW-1:0] tag_of(input logic [DW-1:0] pc);
        return pc / (4 * NE);
    endfunction

    function automatic bit model_taken(input logic [DW-1:0] pc);
        int i;
        i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [DW-1:0] model_pc(input logic [DW-1:0] pc);
        if (model_taken(pc)) return m_target[idx_of(pc)];
        return pc + 64'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i]  = 0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_lookups = 0;
        m_mispred = 0;
    endtask

    task automatic model_clock();
        int  i;
        bit  hit;
        if (lookup_en && m_lookups < 64'hFFFF_FFFF) m_lookups++;
        if (update_valid && update_mispredict && m_mispred < 64'hFFFF_FFFF)
            m_mispred++;
        if (flush_all) begin
            for (int k = 0; k < NE; k++) m_valid[k] = 0;
        end else if (update_valid) begin
            i   = idx_of(update_pc);
            hit = m_valid[i] && (m_tag[i] == tag_of(update_pc));
            if (hit && update_taken) begin
                m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = update_target;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end else if (update_taken) begin
                m_valid[i]  = 1;
                m_tag[i]    = tag_of(update_pc);
                m_target[i] = update_target;
                m_ctr[i]    = 2;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    endtask

    task automatic check_outputs(input string nm);
        logic [31:0] el;
        logic [31:0] em;
`ifdef BTP_STATS_EN
        el = 32'(m_lookups);
        em = 32'(m_mispred);
`else
        el = 32'd0;
        em = 32'd0;
`endif
        chk({nm, ".taken"}, 64'(predict_taken), 64'(model_taken(lookup_pc)));
        chk({nm, ".pc"}, predict_pc, model_pc(lookup_pc));
        chk({nm, ".stat_lk"}, 64'(stat_lookups), 64'(el));
        chk({nm, ".stat_mp"}, 64'(stat_mispredicts), 64'(em));
    endtask

    // One cycle: drive after the falling edge, check before the rising edge.
    task automatic step(input string nm, input logic le,
                        input logic [DW-1:0] lpc, input logic uv,
                        input logic [DW-1:0] upc, input logic [DW-1:0] utg,
                        input logic ut, input logic um, input logic fl);
        lookup_en         = le;
        lookup_pc         = lpc;
        update_valid      = uv;
        update_pc         = upc;
        update_target     = utg;
        update_taken      = ut;
        update_mispredict = um;
        flush_all         = fl;
        #2;
        check_outputs(nm);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic look(input string nm, input logic [DW-1:0] pc);
        step(nm, 1'b0, pc, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic upd(input string nm, input logic [DW-1:0] pc,
                       input logic [DW-1:0] tg, input logic tk);
        step(nm, 1'b0, pc, 1'b1, pc, tg, tk, 1'b0, 1'b0);
    endtask

    function automatic logic [DW-1:0] rand_pc();
        logic [DW-1:0] pc;
        pc = (64'($urandom_range(0, 3)) << 6)
           | (64'($urandom_range(0, 15)) << 2)
           | 64'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) pc = pc | 64'hF000_0000_0000_0000;
        return pc;
    endfunction

    initial begin
        arst              = 1'b1;
        lookup_en         = 1'b0;
        lookup_pc         = 64'h100;
        update_valid      = 1'b0;
        update_pc         = '0;
        update_target     = '0;
        update_taken      = 1'b0;
        update_mispredict = 1'b0;
        flush_all         = 1'b0;
        model_reset();
        #3;
        check_outputs("in_reset");
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;

        look("reset_lookup", 64'h100);
        // Same-cycle lookup sees the pre-update (miss) state.
        step("alloc_bypass", 1'b0, 64'h100, 1'b1, 64'h100, 64'h40,
             1'b1, 1'b0, 1'b0);
        look("alloc_hit", 64'h100);
        upd("nt1", 64'h100, 64'h0, 1'b0);
        look("after_nt1", 64'h100);
        upd("nt2", 64'h100, 64'h0, 1'b0);
        look("after_nt2", 64'h100);
        upd("nt3_sat", 64'h100, 64'h0, 1'b0);
        upd("t1", 64'h100, 64'h48, 1'b1);
        look("after_t1", 64'h100);
        upd("t2", 64'h100, 64'h4c, 1'b1);
        look("after_t2", 64'h100);
        upd("t3", 64'h100, 64'h50, 1'b1);
        upd("t4_sat", 64'h100, 64'h54, 1'b1);
        upd("nt_from_st", 64'h100, 64'h0, 1'b0);
        look("still_taken", 64'h100);
        upd("nt_again", 64'h100, 64'h0, 1'b0);
        look("now_wnt", 64'h100);

        upd("realloc_100", 64'h100, 64'h40, 1'b1);
        upd("alloc_140", 64'h140, 64'h80, 1'b1);
        look("conflict_100", 64'h100);
        look("conflict_140", 64'h140);
        upd("nt_miss_300", 64'h300, 64'h90, 1'b0);
        look("no_alloc_300", 64'h300);

        step("flush_upd", 1'b0, 64'h140, 1'b1, 64'h200, 64'h60,
             1'b1, 1'b0, 1'b1);
        look("flush_200", 64'h200);
        look("flush_140", 64'h140);
        look("wrap_pc", 64'hFFFF_FFFF_FFFF_FFFC);
        upd("hi_alloc", 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234, 1'b1);
        look("hi_hit", 64'hFFFF_FFFF_FFFF_FFFE);

        for (int i = 0; i < 10; i++) begin
            step("stat_lk", 1'b1, 64'h500, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step("stat_mp", 1'b0, 64'h500, 1'b1, 64'h600, 64'h0,
                 1'b0, 1'b1, 1'b0);
        end
        look("stat_total", 64'h500);

        for (int n = 0; n < 400; n++) begin
            step("rand", 1'($urandom), rand_pc(),
                 1'($urandom_range(0, 3) != 0), rand_pc(),
                 {32'($urandom), 32'($urandom)}, 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 39) == 0));
        end

        // Reset arriving mid-update: the update is lost.
        upd("pre_rst", 64'h340, 64'h700, 1'b1);
        lookup_pc     = 64'h340;
        update_valid  = 1'b1;
        update_pc     = 64'h380;
        update_target = 64'h800;
        update_taken  = 1'b1;
        lookup_en     = 1'b1;
        #2;
        arst = 1'b1;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        arst         = 1'b0;
        update_valid = 1'b0;
        look("rst_340", 64'h340);
        look("rst_380", 64'h380);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
